// File: rtl/alu_word_sequencer_if.sv
// Request/response bundle between a requester and the word sequencer.
// Latency: none, wires only.
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the response side.
interface alu_word_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_carry;
  logic        resp_zero;
  logic        resp_err;

  // Requester side
  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_carry, resp_zero, resp_err
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_carry, resp_zero, resp_err
  );
endinterface

// File: rtl/alu_word_sequencer.sv
// Runs one 32-bit op as four LSB-first byte steps on an external combinational 8-bit ALU.
// Latency: resp_valid 4 cycles after accept for legal ops; illegal ops respond in the cycle right after accept.
// Backpressure: req_ready only in IDLE; the response is held in DONE until resp_ready.
module alu_word_sequencer #(
  parameter logic [3:0] P_ADD  = 4'd0,
  parameter logic [3:0] P_ADDC = 4'd1,
  parameter logic [3:0] P_SUB  = 4'd2,
  parameter logic [3:0] P_SUBC = 4'd3,
  parameter logic [3:0] P_AND  = 4'd4,
  parameter logic [3:0] P_OR   = 4'd5,
  parameter logic [3:0] P_XOR  = 4'd6,
  parameter logic [3:0] P_MASK = 4'd7
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_word_sequencer_if.slave  bus,
  output logic [7:0]           alu_in1,
  output logic [7:0]           alu_in2,
  output logic                 cin,
  output logic [3:0]           opcode,
  input  logic [7:0]           alu_out,
  input  logic                 cout,
  input  logic                 Z
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MASK = 3'd5;

  state_t      state;
  logic [1:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [23:0] acc;     // bytes 0..2 collected so far, newest byte enters at the top
  logic        zacc;    // AND of the Z flags seen so far
  logic [1:0]  next_k;
  logic        arith;

  assign next_k = cnt + 2'd1;
  assign arith  = (op_q == OP_ADD) || (op_q == OP_SUB);

  // ALU opcode for a request op; the first byte of ADD/SUB has no carry/borrow in
  function automatic logic [3:0] step_opcode(input logic [2:0] op, input logic first);
    case (op)
      OP_ADD:  return first ? P_ADD : P_ADDC;
      OP_SUB:  return first ? P_SUB : P_SUBC;
      OP_AND:  return P_AND;
      OP_OR:   return P_OR;
      OP_XOR:  return P_XOR;
      OP_MASK: return P_MASK;
      default: return P_ADD;
    endcase
  endfunction

  // Control FSM; ALU drive and response fields are registered so they are set up one edge ahead
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 2'd0;
      op_q            <= 3'd0;
      a_q             <= 32'd0;
      b_q             <= 32'd0;
      acc             <= 24'd0;
      zacc            <= 1'b0;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_result <= 32'd0;
      bus.resp_carry  <= 1'b0;
      bus.resp_zero   <= 1'b0;
      bus.resp_err    <= 1'b0;
      alu_in1         <= 8'd0;
      alu_in2         <= 8'd0;
      cin             <= 1'b0;
      opcode          <= P_ADD;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q          <= bus.req_op;
            a_q           <= bus.req_a;
            b_q           <= bus.req_b;
            bus.req_ready <= 1'b0;
            if (bus.req_op <= OP_MASK) begin
              state   <= EXEC;
              cnt     <= 2'd0;
              zacc    <= 1'b1;
              alu_in1 <= bus.req_a[7:0];
              alu_in2 <= bus.req_b[7:0];
              cin     <= 1'b0;
              opcode  <= step_opcode(bus.req_op, 1'b1);
            end else begin
              // Illegal op: answer straight away, the ALU is never driven
              state           <= DONE;
              bus.resp_valid  <= 1'b1;
              bus.resp_result <= 32'd0;
              bus.resp_carry  <= 1'b0;
              bus.resp_zero   <= 1'b1;
              bus.resp_err    <= 1'b1;
            end
          end
        end

        EXEC: begin
          acc  <= {alu_out, acc[23:8]};
          zacc <= zacc & Z;
          if (cnt == 2'd3) begin
            state           <= DONE;
            bus.resp_valid  <= 1'b1;
            bus.resp_result <= {alu_out, acc};
            bus.resp_carry  <= arith ? cout : 1'b0;
            bus.resp_zero   <= zacc & Z;
            bus.resp_err    <= 1'b0;
            alu_in1         <= 8'd0;
            alu_in2         <= 8'd0;
            cin             <= 1'b0;
            opcode          <= P_ADD;
          end else begin
            cnt     <= next_k;
            alu_in1 <= a_q[{next_k, 3'b000} +: 8];
            alu_in2 <= b_q[{next_k, 3'b000} +: 8];
            cin     <= arith ? cout : 1'b0;
            opcode  <= step_opcode(op_q, 1'b0);
          end
        end

        DONE: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            cnt            <= 2'd0;
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end

        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
